// File: rtl/compare_pkg.sv
// Shared definitions for the compare execution unit: opcode type and the
// six relational opcode encodings. Build option COMPARE_SIGNED_EN (used in
// compare_core) selects two's-complement operand interpretation.
package compare_pkg;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_LT  = 5'b01011;
    localparam opcode_t OP_GT  = 5'b01100;
    localparam opcode_t OP_EQ  = 5'b01101;
    localparam opcode_t OP_GTE = 5'b01110;
    localparam opcode_t OP_LTE = 5'b01111;
    localparam opcode_t OP_NE  = 5'b10000;

    // True when the opcode is one of the six relational operations.
    function automatic logic is_cmp_op(input opcode_t op);
        logic r;
        case (op)
            OP_LT, OP_GT, OP_EQ, OP_GTE, OP_LTE, OP_NE: r = 1'b1;
            default:                                    r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/compare_core.sv
// Combinational comparison primitives (lt, eq) from which all relational
// results are derived. Macro COMPARE_SIGNED_EN switches lt to a signed
// (two's-complement) compare; eq is the same in both builds.
module compare_core #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             lt,
    output logic             eq
);

`ifdef COMPARE_SIGNED_EN
    assign lt = ($signed(a) < $signed(b));
`else
    assign lt = (a < b);
`endif

    assign eq = (a == b);

endmodule

// File: rtl/compare.sv
// Compare-instruction execution unit: decodes the opcode, selects one of six
// relational results derived from lt/eq, and registers a boolean result plus
// a valid flag (one cycle latency). Signedness follows COMPARE_SIGNED_EN.
module compare
    import compare_pkg::*;
#(
    parameter int WIDTH = 3,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] R1,
    input  logic [WIDTH-1:0] R2,
    output logic [WIDTH-1:0] RD,
    output logic             valid
);

    logic             w_lt;
    logic             w_eq;
    logic             w_cond;
    logic             w_is_cmp;
    logic [WIDTH-1:0] r_rd;
    logic             r_valid;

    compare_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a  (R1),
        .b  (R2),
        .lt (w_lt),
        .eq (w_eq)
    );

    // Select the relational result for the current opcode.
    always_comb begin
        w_cond = 1'b0;
        case (opcode)
            OP_LT:   w_cond = w_lt;
            OP_GT:   w_cond = ~w_lt & ~w_eq;
            OP_EQ:   w_cond = w_eq;
            OP_GTE:  w_cond = ~w_lt;
            OP_LTE:  w_cond = w_lt | w_eq;
            OP_NE:   w_cond = ~w_eq;
            default: w_cond = 1'b0;
        endcase
        w_is_cmp = is_cmp_op(opcode);
    end

    // Output register; reset clears any in-flight result immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd    <= {WIDTH{1'b0}};
            r_valid <= 1'b0;
        end else begin
            r_rd    <= {{(WIDTH-1){1'b0}}, w_cond};
            r_valid <= w_is_cmp;
        end
    end

    assign RD    = r_rd;
    assign valid = r_valid;

endmodule

// File: tb/tb_compare.sv
// Self-checking bench for compare: literal expectations for the documented
// cases, plus randomized traffic checked every cycle against a behavioural
// model. Honors COMPARE_SIGNED_EN for both model and literal table.
module tb_compare;
    import compare_pkg::*;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   opcode = 5'b00000;
    logic [W-1:0] R1 = 3'd0;
    logic [W-1:0] R2 = 3'd0;
    logic [W-1:0] RD;
    logic         valid;

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;
    logic exp_rd = 1'b0;
    logic exp_valid = 1'b0;

    compare #(.WIDTH(W), .OPW(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .opcode (opcode),
        .R1     (R1),
        .R2     (R2),
        .RD     (RD),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    // Operand value as seen by the comparison (two's complement if signed build).
    function automatic int opval(input logic [W-1:0] x);
        int v;
        v = int'(x);
`ifdef COMPARE_SIGNED_EN
        if (v >= 4) v = v - 8;
`endif
        return v;
    endfunction

    function automatic logic model_rd(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int x, y;
        x = opval(a);
        y = opval(b);
        case (op)
            5'b01011: return x <  y;
            5'b01100: return x >  y;
            5'b01101: return x == y;
            5'b01110: return x >= y;
            5'b01111: return x <= y;
            5'b10000: return x != y;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic model_valid(input logic [4:0] op);
        return (op >= 5'd11) && (op <= 5'd16);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: result of the inputs seen at the last edge, cleared by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_rd    = 1'b0;
            exp_valid = 1'b0;
        end else begin
            exp_rd    = model_rd(opcode, R1, R2);
            exp_valid = model_valid(opcode);
        end
    end

    // Per-cycle comparison of DUT outputs against the model, mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_RD", int'(RD), int'({2'b00, exp_rd}));
            chk("cyc_valid", int'(valid), int'(exp_valid));
        end
    end

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         rd;
        logic         v;
    } vec_t;

`ifdef COMPARE_SIGNED_EN
    localparam int NV = 8;
    vec_t vecs[NV] = '{
        '{OP_LT,  3'd7, 3'd3, 1'b1, 1'b1},
        '{OP_GT,  3'd3, 3'd7, 1'b1, 1'b1},
        '{OP_LT,  3'd3, 3'd5, 1'b0, 1'b1},
        '{OP_EQ,  3'd2, 3'd2, 1'b1, 1'b1},
        '{OP_GTE, 3'd4, 3'd4, 1'b1, 1'b1},
        '{OP_LTE, 3'd4, 3'd3, 1'b1, 1'b1},
        '{OP_NE,  3'd2, 3'd6, 1'b1, 1'b1},
        '{5'b00000, 3'd3, 3'd5, 1'b0, 1'b0}
    };
`else
    localparam int NV = 19;
    vec_t vecs[NV] = '{
        '{OP_LT,  3'd5, 3'd3, 1'b0, 1'b1},
        '{OP_LT,  3'd3, 3'd3, 1'b0, 1'b1},
        '{OP_LT,  3'd0, 3'd7, 1'b1, 1'b1},
        '{OP_GT,  3'd7, 3'd3, 1'b1, 1'b1},
        '{OP_GT,  3'd3, 3'd7, 1'b0, 1'b1},
        '{OP_GT,  3'd7, 3'd7, 1'b0, 1'b1},
        '{OP_EQ,  3'd2, 3'd2, 1'b1, 1'b1},
        '{OP_EQ,  3'd1, 3'd6, 1'b0, 1'b1},
        '{OP_EQ,  3'd7, 3'd7, 1'b1, 1'b1},
        '{OP_GTE, 3'd6, 3'd1, 1'b1, 1'b1},
        '{OP_GTE, 3'd4, 3'd4, 1'b1, 1'b1},
        '{OP_GTE, 3'd2, 3'd4, 1'b0, 1'b1},
        '{OP_LTE, 3'd2, 3'd6, 1'b1, 1'b1},
        '{OP_LTE, 3'd7, 3'd7, 1'b1, 1'b1},
        '{OP_LTE, 3'd7, 3'd3, 1'b0, 1'b1},
        '{OP_NE,  3'd2, 3'd6, 1'b1, 1'b1},
        '{OP_NE,  3'd2, 3'd2, 1'b0, 1'b1},
        '{5'b00000, 3'd3, 3'd5, 1'b0, 1'b0},
        '{OP_LT,  3'd3, 3'd5, 1'b1, 1'b1}
    };
`endif

    // Issue one op now; check its result one edge later against literals.
    task automatic direct(input vec_t v, input int idx);
        opcode = v.op;
        R1     = v.a;
        R2     = v.b;
        @(posedge clk);
        #1;
        chk($sformatf("lit%0d_RD", idx), int'(RD), int'({2'b00, v.rd}));
        chk($sformatf("lit%0d_valid", idx), int'(valid), int'(v.v));
        chk($sformatf("lit%0d_model", idx), int'(model_rd(v.op, v.a, v.b)), int'(v.rd));
    endtask

    opcode_t ops[6] = '{OP_LT, OP_GT, OP_EQ, OP_GTE, OP_LTE, OP_NE};

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk("reset_RD", int'(RD), 0);
        chk("reset_valid", int'(valid), 0);
        chk_en = 1'b1;
        #5 rst_n = 1'b1;

        // LT (3,5) then async reset mid-cycle
        opcode = OP_LT; R1 = 3'd3; R2 = 3'd5;
        @(posedge clk);
        #1;
        chk("pre_reset_RD", int'(RD), 1);
        chk("pre_reset_valid", int'(valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_RD", int'(RD), 0);
        chk("async_reset_valid", int'(valid), 0);
        #2 rst_n = 1'b1;

        // Documented cases, issued back-to-back
        for (int i = 0; i < NV; i++) direct(vecs[i], i);

        // Randomized traffic with occasional mid-cycle resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) opcode = 5'($urandom);
            else opcode = ops[$urandom_range(0, 5)];
            R1 = 3'($urandom);
            R2 = 3'($urandom);
            @(posedge clk);
            #1;
            if ((i % 97) == 50) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rand_reset_RD", int'(RD), 0);
                chk("rand_reset_valid", int'(valid), 0);
                #2 rst_n = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
